// File: rtl/fpu_misc_pipe.sv
`default_nettype none
//============================================================================
// Module   : fpu_misc_pipe
// Desc     : Two-stage pipe for FP sign injection, min/max, compares and,
//            when FPU_FCLASS_EN is defined, FCLASS (op 8).
// Revision : 1.0  initial release
//============================================================================
module fpu_misc_pipe #(
    parameter int FLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [FLEN-1:0] rs1,
    input  logic [FLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] result,
    output logic [4:0]      fflags
);

    localparam int c_EXP = (FLEN == 64) ? 11 : 8;
    localparam int c_MAN = FLEN - 1 - c_EXP;
    localparam logic [FLEN-1:0] c_CANON_NAN =
        {1'b0, {c_EXP{1'b1}}, 1'b1, {(c_MAN-1){1'b0}}};

    localparam logic [3:0] c_OP_FSGNJ  = 4'd0;
    localparam logic [3:0] c_OP_FSGNJN = 4'd1;
    localparam logic [3:0] c_OP_FSGNJX = 4'd2;
    localparam logic [3:0] c_OP_FMIN   = 4'd3;
    localparam logic [3:0] c_OP_FMAX   = 4'd4;
    localparam logic [3:0] c_OP_FEQ    = 4'd5;
    localparam logic [3:0] c_OP_FLT    = 4'd6;
    localparam logic [3:0] c_OP_FLE    = 4'd7;
`ifdef FPU_FCLASS_EN
    localparam logic [3:0] c_OP_FCLASS = 4'd8;
`endif

    // Operand classification, computed before S1 and registered with operands
    logic w_a_exp_ones, w_a_exp_zero, w_a_man_zero;
    logic w_b_exp_ones, w_b_exp_zero, w_b_man_zero;
    logic w_a_nan, w_a_snan, w_a_zero, w_b_nan, w_b_snan, w_b_zero;

    assign w_a_exp_ones = &rs1[FLEN-2 -: c_EXP];
    assign w_a_exp_zero = ~|rs1[FLEN-2 -: c_EXP];
    assign w_a_man_zero = ~|rs1[c_MAN-1:0];
    assign w_b_exp_ones = &rs2[FLEN-2 -: c_EXP];
    assign w_b_exp_zero = ~|rs2[FLEN-2 -: c_EXP];
    assign w_b_man_zero = ~|rs2[c_MAN-1:0];

    assign w_a_nan  = w_a_exp_ones & ~w_a_man_zero;
    assign w_a_snan = w_a_nan & ~rs1[c_MAN-1];
    assign w_a_zero = w_a_exp_zero & w_a_man_zero;
    assign w_b_nan  = w_b_exp_ones & ~w_b_man_zero;
    assign w_b_snan = w_b_nan & ~rs2[c_MAN-1];
    assign w_b_zero = w_b_exp_zero & w_b_man_zero;

    logic            r_s1_valid;
    logic [3:0]      r_s1_op;
    logic [FLEN-1:0] r_s1_a, r_s1_b;
    logic            r_a_nan, r_a_snan, r_a_zero, r_b_nan, r_b_snan, r_b_zero;
`ifdef FPU_FCLASS_EN
    logic            w_a_inf, w_a_sub, r_a_inf, r_a_sub;
    assign w_a_inf = w_a_exp_ones & w_a_man_zero;
    assign w_a_sub = w_a_exp_zero & ~w_a_man_zero;
`endif

    logic            r_out_valid;
    logic [FLEN-1:0] r_result;
    logic [4:0]      r_fflags;
    logic            w_advance;
    logic            w_in_ready;

    assign w_advance  = ~r_out_valid | out_ready;
    assign w_in_ready = ~r_s1_valid | w_advance;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_a_nan    <= 1'b0;
            r_a_snan   <= 1'b0;
            r_a_zero   <= 1'b0;
            r_b_nan    <= 1'b0;
            r_b_snan   <= 1'b0;
            r_b_zero   <= 1'b0;
`ifdef FPU_FCLASS_EN
            r_a_inf    <= 1'b0;
            r_a_sub    <= 1'b0;
`endif
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op  <= op;
                r_s1_a   <= rs1;
                r_s1_b   <= rs2;
                r_a_nan  <= w_a_nan;
                r_a_snan <= w_a_snan;
                r_a_zero <= w_a_zero;
                r_b_nan  <= w_b_nan;
                r_b_snan <= w_b_snan;
                r_b_zero <= w_b_zero;
`ifdef FPU_FCLASS_EN
                r_a_inf  <= w_a_inf;
                r_a_sub  <= w_a_sub;
`endif
            end
        end
    end

    // Ordering: w_tot_lt is a total order with -0 < +0 (min/max);
    // w_lt is the IEEE relation where the two zeros compare equal.
    logic w_sa, w_sb, w_mag_lt, w_mag_gt, w_tot_lt, w_lt, w_eq;
    logic w_any_nan, w_any_snan;

    assign w_sa       = r_s1_a[FLEN-1];
    assign w_sb       = r_s1_b[FLEN-1];
    assign w_mag_lt   = r_s1_a[FLEN-2:0] < r_s1_b[FLEN-2:0];
    assign w_mag_gt   = r_s1_a[FLEN-2:0] > r_s1_b[FLEN-2:0];
    assign w_tot_lt   = (w_sa != w_sb) ? w_sa : (w_sa ? w_mag_gt : w_mag_lt);
    assign w_lt       = w_tot_lt & ~(r_a_zero & r_b_zero);
    assign w_eq       = (r_s1_a == r_s1_b) | (r_a_zero & r_b_zero);
    assign w_any_nan  = r_a_nan | r_b_nan;
    assign w_any_snan = r_a_snan | r_b_snan;

`ifdef FPU_FCLASS_EN
    logic [9:0] w_class;
    logic       w_a_norm;
    assign w_a_norm = ~(r_a_inf | r_a_nan | r_a_sub | r_a_zero);
    assign w_class  = {r_a_nan & ~r_a_snan, r_a_snan,
                       ~w_sa & r_a_inf,  ~w_sa & w_a_norm,
                       ~w_sa & r_a_sub,  ~w_sa & r_a_zero,
                       w_sa & r_a_zero,  w_sa & r_a_sub,
                       w_sa & w_a_norm,  w_sa & r_a_inf};
`endif

    logic [FLEN-1:0] w_res;
    logic            w_nv;

    always_comb begin
        w_res = '0;
        w_nv  = 1'b0;
        case (r_s1_op)
            c_OP_FSGNJ:  w_res = {w_sb, r_s1_a[FLEN-2:0]};
            c_OP_FSGNJN: w_res = {~w_sb, r_s1_a[FLEN-2:0]};
            c_OP_FSGNJX: w_res = {w_sa ^ w_sb, r_s1_a[FLEN-2:0]};
            c_OP_FMIN, c_OP_FMAX: begin
                w_nv = w_any_snan;
                if (r_a_nan && r_b_nan)
                    w_res = c_CANON_NAN;
                else if (r_a_nan)
                    w_res = r_s1_b;
                else if (r_b_nan)
                    w_res = r_s1_a;
                else if ((r_s1_op == c_OP_FMIN) == w_tot_lt)
                    w_res = r_s1_a;
                else
                    w_res = r_s1_b;
            end
            c_OP_FEQ: begin
                w_nv  = w_any_snan;
                w_res = {{(FLEN-1){1'b0}}, ~w_any_nan & w_eq};
            end
            c_OP_FLT: begin
                w_nv  = w_any_nan;
                w_res = {{(FLEN-1){1'b0}}, ~w_any_nan & w_lt};
            end
            c_OP_FLE: begin
                w_nv  = w_any_nan;
                w_res = {{(FLEN-1){1'b0}}, ~w_any_nan & (w_lt | w_eq)};
            end
`ifdef FPU_FCLASS_EN
            c_OP_FCLASS: w_res = {{(FLEN-10){1'b0}}, w_class};
`endif
            default: w_nv = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_fflags    <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_fflags <= {w_nv, 4'b0000};
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign fflags    = r_fflags;

endmodule
`default_nettype wire

// File: tb/tb_fpu_misc_pipe.sv
`default_nettype none
//============================================================================
// Module   : tb_fpu_misc_pipe
// Desc     : Self-checking bench: scoreboard model for a FLEN=32 instance,
//            directed checks on a FLEN=64 instance (FCLASS follows FPU_FCLASS_EN).
// Revision : 1.0  initial release
//============================================================================
module tb_fpu_misc_pipe;

    localparam logic [3:0] OP_FSGNJ = 4'd0, OP_FSGNJN = 4'd1, OP_FSGNJX = 4'd2,
                           OP_FMIN = 4'd3, OP_FMAX = 4'd4, OP_FEQ = 4'd5,
                           OP_FLT = 4'd6, OP_FLE = 4'd7, OP_FCLASS = 4'd8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [3:0]  op = '0;
    logic [31:0] rs1 = '0, rs2 = '0, result;
    logic [4:0]  fflags;

    logic        v64 = 1'b0, rdy64, ov64;
    logic [3:0]  op64 = '0;
    logic [63:0] a64 = '0, b64 = '0, res64;
    logic [4:0]  ff64;

    fpu_misc_pipe #(.FLEN(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .fflags(fflags));

    fpu_misc_pipe #(.FLEN(64)) dut64 (
        .clk(clk), .resetn(resetn), .in_valid(v64), .in_ready(rdy64),
        .op(op64), .rs1(a64), .rs2(b64), .out_valid(ov64),
        .out_ready(1'b1), .result(res64), .fflags(ff64));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: values are reduced to a signed ordering key
    // (sign-magnitude -> two's complement), so +0 and -0 share key 0.
    function automatic void model(input int w, input logic [3:0] o,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [4:0] f);
        int          e = (w == 64) ? 11 : 8;
        int          m = w - 1 - e;
        logic [63:0] magmask = (64'd1 << (w - 1)) - 64'd1;
        logic [63:0] manmask = (64'd1 << m) - 64'd1;
        logic [63:0] expall = (64'd1 << e) - 64'd1;
        logic [63:0] amag = a & magmask, bmag = b & magmask;
        logic        as = a[w-1], bs = b[w-1];
        logic        a_eo = ((a >> m) & expall) == expall;
        logic        b_eo = ((b >> m) & expall) == expall;
        logic        a_ez = ((a >> m) & expall) == 64'd0;
        logic        a_nan = a_eo && (a & manmask) != 0;
        logic        b_nan = b_eo && (b & manmask) != 0;
        logic        a_sn = a_nan && !a[m-1];
        logic        b_sn = b_nan && !b[m-1];
        longint      ka = as ? -longint'(amag) : longint'(amag);
        longint      kb = bs ? -longint'(bmag) : longint'(bmag);
        logic [63:0] canon = (w == 32) ? 64'h7FC00000 : 64'h7FF8000000000000;
        logic [63:0] lo, hi;
        int          idx;
        r = '0;
        f = '0;
        if (ka != kb) begin
            lo = (ka < kb) ? a : b;
            hi = (ka < kb) ? b : a;
        end else begin
            lo = as ? a : b;
            hi = as ? b : a;
        end
        case (o)
            OP_FSGNJ:  r = amag | ({63'd0, bs} << (w - 1));
            OP_FSGNJN: r = amag | ({63'd0, !bs} << (w - 1));
            OP_FSGNJX: r = amag | ({63'd0, as ^ bs} << (w - 1));
            OP_FMIN, OP_FMAX: begin
                if (a_nan && b_nan) r = canon;
                else if (a_nan)     r = b;
                else if (b_nan)     r = a;
                else                r = (o == OP_FMIN) ? lo : hi;
                f = {a_sn || b_sn, 4'b0};
            end
            OP_FEQ: begin r = 64'(!a_nan && !b_nan && ka == kb); f = {a_sn || b_sn, 4'b0}; end
            OP_FLT: begin r = 64'(!a_nan && !b_nan && ka < kb);  f = {a_nan || b_nan, 4'b0}; end
            OP_FLE: begin r = 64'(!a_nan && !b_nan && ka <= kb); f = {a_nan || b_nan, 4'b0}; end
`ifdef FPU_FCLASS_EN
            OP_FCLASS: begin
                if (a_nan)           idx = a_sn ? 8 : 9;
                else if (a_eo)       idx = as ? 0 : 7;
                else if (amag == 0)  idx = as ? 3 : 4;
                else if (a_ez)       idx = as ? 2 : 5;
                else                 idx = as ? 1 : 6;
                r = 64'd1 << idx;
            end
`endif
            default: f = 5'h10;
        endcase
    endfunction

    typedef struct { logic [63:0] r; logic [4:0] f; } exp_t;
    exp_t        exp_q[$];
    logic        held_v = 1'b0;
    logic [31:0] held_r;
    logic [4:0]  held_f;
    logic        saw_stall = 1'b0;

    // Compare process for the FLEN=32 instance, sampled between edges
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_result", 64'(result), 64'(held_r));
                chk("hold_fflags", 64'(fflags), 64'(held_f));
            end
            held_v = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("result", 64'(result), exp_q[0].r);
                    chk("fflags", 64'(fflags), 64'(exp_q[0].f));
                    if (out_ready) void'(exp_q.pop_front());
                    else begin
                        held_v = 1'b1;
                        held_r = result;
                        held_f = fflags;
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(32, op, 64'(rs1), 64'(rs2), e.r, e.f);
                exp_q.push_back(e);
            end
            if (in_valid && !in_ready) saw_stall = 1'b1;
        end
    end

    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ok;
        int   n = 0;
        in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("send_timeout", 64'(ok), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run64(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic [4:0] f);
        int n = 0;
        v64 = 1'b1; op64 = o; a64 = a; b64 = b;
        @(negedge clk);
        chk("in_ready64", 64'(rdy64), 64'd1);
        @(posedge clk);
        #1;
        v64 = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov64 && n < 20);
        chk("out_valid64", 64'(ov64), 64'd1);
        r = res64;
        f = ff64;
    endtask

    logic [63:0] mr, dr;
    logic [4:0]  mf, df;

    initial begin
        // Hand-computed anchors for the model itself
        model(32, OP_FMIN, 64'h80000000, 64'h00000000, mr, mf);
        chk("pin_fmin_r", mr, 64'h80000000);   chk("pin_fmin_f", 64'(mf), 64'h00);
        model(32, OP_FLT, 64'h7FC00000, 64'h3F800000, mr, mf);
        chk("pin_flt_r", mr, 64'h0);           chk("pin_flt_f", 64'(mf), 64'h10);
        model(32, OP_FEQ, 64'h7FC00000, 64'h3F800000, mr, mf);
        chk("pin_feq_r", mr, 64'h0);           chk("pin_feq_f", 64'(mf), 64'h00);
        model(32, OP_FMAX, 64'h7F800001, 64'h7FC00000, mr, mf);
        chk("pin_fmax_r", mr, 64'h7FC00000);   chk("pin_fmax_f", 64'(mf), 64'h10);
        model(32, OP_FLE, 64'hC0000000, 64'hBF800000, mr, mf);
        chk("pin_fle_r", mr, 64'h1);
        model(64, OP_FCLASS, 64'hFFF0000000000000, 64'h0, mr, mf);
`ifdef FPU_FCLASS_EN
        chk("pin_fclass_r", mr, 64'h1);        chk("pin_fclass_f", 64'(mf), 64'h00);
`else
        chk("pin_fclass_r", mr, 64'h0);        chk("pin_fclass_f", 64'(mf), 64'h10);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_fflags", 64'(fflags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted at one edge, visible after the second edge
        send(OP_FMIN, 32'h80000000, 32'h00000000);
        @(negedge clk);
        chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
        chk("lat_result", 64'(result), 64'h80000000);
        chk("lat_fflags", 64'(fflags), 64'h00);
        drain();

        // Directed vectors through the scoreboard
        send(OP_FLT,    32'h7FC00000, 32'h3F800000);
        send(OP_FEQ,    32'h7FC00000, 32'h3F800000);
        send(OP_FMAX,   32'h7F800001, 32'h7FC00000);
        send(OP_FSGNJ,  32'h3F800000, 32'h80000000);
        send(OP_FSGNJN, 32'h7F800001, 32'h00000000);
        send(OP_FSGNJX, 32'hC0400000, 32'h80000000);
        send(OP_FMAX,   32'h80000000, 32'h00000000);
        send(OP_FMIN,   32'h7FC00000, 32'hC1200000);
        send(OP_FMIN,   32'h3F800000, 32'h7F800001);
        send(OP_FEQ,    32'h80000000, 32'h00000000);
        send(OP_FEQ,    32'h7F800001, 32'h7F800001);
        send(OP_FLT,    32'hC0000000, 32'hBF800000);
        send(OP_FLE,    32'h40000000, 32'h40000000);
        send(OP_FLE,    32'h3F800000, 32'hFF800000);
        send(OP_FCLASS, 32'h00000001, 32'h0);
        send(4'd12,     32'h3F800000, 32'h3F800000);
        send(4'd15,     32'h0,        32'h0);
        drain();

        // Back-to-back burst with a 3-cycle output stall mid-stream
        saw_stall = 1'b0;
        fork
            begin
                send(OP_FMIN, 32'h40400000, 32'h40000000);
                send(OP_FMAX, 32'h40400000, 32'h40000000);
                send(OP_FLT,  32'h00000001, 32'h00000002);
                send(OP_FSGNJN, 32'h12345678, 32'h80000000);
                send(OP_FLE,  32'hFF800000, 32'h7F800000);
                send(OP_FEQ,  32'h3F800000, 32'h3F800001);
                send(OP_FMIN, 32'hBF800000, 32'hC0000000);
                send(OP_FSGNJX, 32'hBF800000, 32'hBF800000);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("in_ready_dropped", 64'(saw_stall), 64'd1);

        // Reset with two requests in flight
        out_ready = 1'b0;
        send(OP_FMAX, 32'h3F800000, 32'h40000000);
        send(OP_FMIN, 32'h3F800000, 32'h40000000);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_fflags", 64'(fflags), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // FLEN=64 instance
        run64(OP_FCLASS, 64'hFFF0000000000000, 64'h0, dr, df);
        model(64, OP_FCLASS, 64'hFFF0000000000000, 64'h0, mr, mf);
        chk("f64_fclass_r", dr, mr);           chk("f64_fclass_f", 64'(df), 64'(mf));
        run64(OP_FMAX, 64'h7FF0000000000001, 64'h7FF8000000000000, dr, df);
        chk("f64_fmax_nan_r", dr, 64'h7FF8000000000000);
        chk("f64_fmax_nan_f", 64'(df), 64'h10);
        run64(OP_FMIN, 64'h7FF8000000000000, 64'hC000000000000000, dr, df);
        model(64, OP_FMIN, 64'h7FF8000000000000, 64'hC000000000000000, mr, mf);
        chk("f64_fmin_r", dr, mr);             chk("f64_fmin_f", 64'(df), 64'(mf));
        run64(OP_FLT, 64'hC000000000000000, 64'h8000000000000000, dr, df);
        chk("f64_flt_r", dr, 64'h1);           chk("f64_flt_f", 64'(df), 64'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
